fft_peak: RTL and testbench

Post-FFT spectral peak detector; consumes the FFT core's result memory after each transform. On the rising edge of `fft_done` it sweeps the read address over the positive-frequency bins, computes squared magnitude per bin in a pipeline, and reports the strongest bin, its magnitude, and a threshold flag. Sits directly downstream of the FFT core. During a scan it owns the core's `add_rd` port; top level muxes `add_rd` between the loader and this block using `busy`.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_peak_if.sv | 29 ++
 rtl/mag_sq.sv | 55 +++++
 rtl/fft_peak.sv | 152 +++++++++++++++
 tb/tb_fft_peak.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the post-FFT spectral peak detector.
package fft_pkg;

    localparam int DEF_BIT_WIDTH = 16;
    localparam int DEF_N         = 9;
    localparam int NUM_BINS      = 2**(DEF_N-1);

    // Squared magnitude of a {re, im} pair needs one bit beyond the square width
    function automatic int mag_width(input int bit_width);
        return 2*bit_width + 1;
    endfunction

    localparam int MAG_W = mag_width(DEF_BIT_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } peak_state_t;

endpackage

// File: rtl/fft_peak_if.sv
// Signal bundle between the FFT core / system side (master) and the peak detector (slave).
interface fft_peak_if
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int N         = DEF_N
);

    logic                   fft_done;
    logic [2*BIT_WIDTH-1:0] dout;
    logic [2*BIT_WIDTH:0]   thresh;
    logic [N-1:0]           add_rd;
    logic                   busy;
    logic [N-2:0]           peak_bin;
    logic [2*BIT_WIDTH:0]   peak_mag;
    logic                   peak_found;
    logic                   peak_valid;

    modport master (
        output fft_done, dout, thresh,
        input  add_rd, busy, peak_bin, peak_mag, peak_found, peak_valid
    );

    modport slave (
        input  fft_done, dout, thresh,
        output add_rd, busy, peak_bin, peak_mag, peak_found, peak_valid
    );

endinterface

// File: rtl/mag_sq.sv
// Three-stage pipelined re^2 + im^2 on a packed {re, im} two's complement word.
module mag_sq #(
    parameter int BIT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [2*BIT_WIDTH-1:0] din,
    output logic                   out_valid,
    output logic [2*BIT_WIDTH:0]   mag
);

    localparam int W  = BIT_WIDTH;
    localparam int SW = 2*BIT_WIDTH;

    logic signed [W-1:0]  re_r;
    logic signed [W-1:0]  im_r;
    logic signed [SW-1:0] re_ext_s;
    logic signed [SW-1:0] im_ext_s;
    logic signed [SW-1:0] re_prod_s;
    logic signed [SW-1:0] im_prod_s;
    logic [SW-1:0]        re_sq_r;
    logic [SW-1:0]        im_sq_r;
    logic [SW:0]          sum_r;
    logic [2:0]           vld_r;

    // Squares are formed at full width so (-2^(W-1))^2 does not wrap
    assign re_ext_s  = {{W{re_r[W-1]}}, re_r};
    assign im_ext_s  = {{W{im_r[W-1]}}, im_r};
    assign re_prod_s = re_ext_s * re_ext_s;
    assign im_prod_s = im_ext_s * im_ext_s;

    // Capture, square and sum stages with the valid bit travelling alongside
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r   <= 3'b000;
            re_r    <= '0;
            im_r    <= '0;
            re_sq_r <= '0;
            im_sq_r <= '0;
            sum_r   <= '0;
        end else begin
            vld_r   <= {vld_r[1:0], in_valid};
            re_r    <= din[SW-1:W];
            im_r    <= din[W-1:0];
            re_sq_r <= re_prod_s;
            im_sq_r <= im_prod_s;
            sum_r   <= {1'b0, re_sq_r} + {1'b0, im_sq_r};
        end
    end

    assign out_valid = vld_r[2];
    assign mag       = sum_r;

endmodule

// File: rtl/fft_peak.sv
// Scans the positive-frequency bins of the FFT result memory after each transform
// and reports the strongest bin, its squared magnitude and a threshold flag.
module fft_peak
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int N         = DEF_N
) (
    input  logic     clk,
    input  logic     reset,
    fft_peak_if.slave bus
);

    localparam int MW = mag_width(BIT_WIDTH);
    localparam int BW = N - 1;
    localparam logic [N-1:0] LAST_ADDR  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] ADDR_ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [1:0]   DRAIN_LAST = 2'd3;

    peak_state_t          state_r;
    logic                 done_d_r;
    logic [N-1:0]         add_rd_r;
    logic                 busy_r;
    logic [1:0]           drain_cnt_r;
    logic [MW-1:0]        thresh_r;
    logic [MW-1:0]        max_mag_r;
    logic [BW-1:0]        max_bin_r;
    logic [MW-1:0]        peak_mag_r;
    logic [BW-1:0]        peak_bin_r;
    logic                 peak_found_r;
    logic                 peak_valid_r;
    logic                 in_valid_r;
    logic [3:0][BW-1:0]   bin_dly_r;
    logic                 mag_valid_s;
    logic [MW-1:0]        mag_s;
    logic [MW-1:0]        nxt_max_mag_s;
    logic [BW-1:0]        nxt_max_bin_s;
    logic                 scan_start_s;

    assign scan_start_s = bus.fft_done && !done_d_r;

    mag_sq #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_mag_sq (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid_r),
        .din       (bus.dout),
        .out_valid (mag_valid_s),
        .mag       (mag_s)
    );

    // Read data lags the address by one cycle; stage 0 lines the bin index up with dout
    always_ff @(posedge clk) begin
        if (reset) begin
            in_valid_r <= 1'b0;
            bin_dly_r  <= '0;
        end else begin
            in_valid_r <= (state_r == SCAN);
            bin_dly_r  <= {bin_dly_r[2:0], add_rd_r[BW-1:0]};
        end
    end

    // Strictly-greater update keeps the lowest bin on ties
    always_comb begin
        nxt_max_mag_s = max_mag_r;
        nxt_max_bin_s = max_bin_r;
        if (mag_valid_s && (mag_s > max_mag_r)) begin
            nxt_max_mag_s = mag_s;
            nxt_max_bin_s = bin_dly_r[3];
        end else begin
            nxt_max_mag_s = max_mag_r;
            nxt_max_bin_s = max_bin_r;
        end
    end

    // Scan sequencer: edge detect, address sweep, pipeline drain, result publish
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            done_d_r     <= 1'b0;
            add_rd_r     <= '0;
            busy_r       <= 1'b0;
            drain_cnt_r  <= 2'd0;
            thresh_r     <= '0;
            max_mag_r    <= '0;
            max_bin_r    <= '0;
            peak_mag_r   <= '0;
            peak_bin_r   <= '0;
            peak_found_r <= 1'b0;
            peak_valid_r <= 1'b0;
        end else begin
            done_d_r     <= bus.fft_done;
            peak_valid_r <= 1'b0;
            max_mag_r    <= nxt_max_mag_s;
            max_bin_r    <= nxt_max_bin_s;
            case (state_r)
                IDLE: begin
                    if (scan_start_s) begin
                        state_r   <= SCAN;
                        add_rd_r  <= ADDR_ONE;
                        busy_r    <= 1'b1;
                        thresh_r  <= bus.thresh;
                        max_mag_r <= '0;
                        max_bin_r <= '0;
                    end else begin
                        add_rd_r <= '0;
                        busy_r   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (add_rd_r == LAST_ADDR) begin
                        state_r     <= DRAIN;
                        add_rd_r    <= '0;
                        drain_cnt_r <= 2'd0;
                    end else begin
                        add_rd_r <= add_rd_r + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    // Final bin leaves the pipeline on the last drain cycle
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r      <= DONE;
                        peak_bin_r   <= nxt_max_bin_s;
                        peak_mag_r   <= nxt_max_mag_s;
                        peak_found_r <= (nxt_max_mag_s >= thresh_r);
                        peak_valid_r <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    add_rd_r <= '0;
                end
            endcase
        end
    end

    assign bus.add_rd     = add_rd_r;
    assign bus.busy       = busy_r;
    assign bus.peak_bin   = peak_bin_r;
    assign bus.peak_mag   = peak_mag_r;
    assign bus.peak_found = peak_found_r;
    assign bus.peak_valid = peak_valid_r;

endmodule

// File: tb/tb_fft_peak.sv
// Directed, table-driven bench for fft_peak with a registered result-memory model.
module tb_fft_peak;
    import fft_pkg::*;

    localparam int BWID = 16;
    localparam int NN   = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_peak_if #(.BIT_WIDTH(BWID), .N(NN)) bus ();

    fft_peak #(.BIT_WIDTH(BWID), .N(NN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:511];
    always @(posedge clk) bus.dout <= mem[bus.add_rd];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        int          bin [3];
        int          re  [3];
        int          im  [3];
        logic [32:0] th;
        int          exp_bin;
        logic [32:0] exp_mag;
        logic        exp_found;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pack_iq(input int re, input int im);
        logic [31:0] w;
        w = {re[15:0], im[15:0]};
        return w;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm,
                           input int b0, input int r0, input int i0,
                           input int b1, input int r1, input int i1,
                           input int b2, input int r2, input int i2,
                           input longint th, input int eb, input longint em, input int ef);
        vec_t v;
        v.name = nm;
        v.bin[0] = b0; v.re[0] = r0; v.im[0] = i0;
        v.bin[1] = b1; v.re[1] = r1; v.im[1] = i1;
        v.bin[2] = b2; v.re[2] = r2; v.im[2] = i2;
        v.th        = th[32:0];
        v.exp_bin   = eb;
        v.exp_mag   = em[32:0];
        v.exp_found = ef[0];
        vecs.push_back(v);
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        for (int j = 0; j < 3; j++)
            if (v.bin[j] >= 0) mem[v.bin[j]] = pack_iq(v.re[j], v.im[j]);
    endtask

    // One scan: cycle c counts from t+1; thresh is scrambled after the start edge
    task automatic run_scan(input logic [32:0] th, output int vcyc, output int npulse,
                            output int addr_err, output int busy_err);
        logic [8:0] ea;
        vcyc = -1; npulse = 0; addr_err = 0; busy_err = 0;
        @(negedge clk);
        bus.thresh   = th;
        bus.fft_done = 1'b1;
        @(negedge clk);
        bus.fft_done = 1'b0;
        bus.thresh   = '1;
        for (int c = 1; c <= 300; c++) begin
            ea = (c <= 255) ? c[8:0] : 9'd0;
            if (bus.add_rd !== ea) addr_err++;
            if (bus.busy !== ((c <= 260) ? 1'b1 : 1'b0)) busy_err++;
            if (bus.peak_valid === 1'b1) begin
                npulse++;
                if (vcyc < 0) vcyc = c;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcyc, npulse, aerr, berr;
        vec_t v;
        reset        = 1'b1;
        bus.fft_done = 1'b0;
        bus.thresh   = '0;
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_add_rd", 64'(bus.add_rd), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_peak_bin", 64'(bus.peak_bin), 64'd0);
        check("rst_peak_mag", 64'(bus.peak_mag), 64'd0);
        check("rst_peak_found", 64'(bus.peak_found), 64'd0);
        check("rst_peak_valid", 64'(bus.peak_valid), 64'd0);

        add_vec("tone37",   37, 1000, 0,   -1, 0, 0,   -1, 0, 0,   0, 37, 1000000, 1);
        add_vec("tie",      10, 300, -400, 20, 300, -400, 15, 100, 100, 250001, 10, 250000, 0);
        add_vec("extremes", 0, 32767, 32767, 255, -32768, -32768, -1, 0, 0, 0, 255, 64'd2147483648, 1);
        add_vec("dc_neg",   0, 32767, 32767, 256, 20000, 0, 5, 1, 0, 2, 5, 1, 0);
        add_vec("th_above", 37, 1000, 0,   -1, 0, 0,   -1, 0, 0,   1000001, 37, 1000000, 0);
        add_vec("th_equal", 37, 1000, 0,   -1, 0, 0,   -1, 0, 0,   1000000, 37, 1000000, 1);
        add_vec("zero_th0", -1, 0, 0,      -1, 0, 0,   -1, 0, 0,   0, 0, 0, 1);
        add_vec("zero_th1", -1, 0, 0,      -1, 0, 0,   -1, 0, 0,   1, 0, 0, 0);
        add_vec("tie_ends", 1, -5, 12,     254, 12, 5, 128, 3, -3, 169, 1, 169, 1);
        add_vec("mixed",    100, -1234, 567, 200, 1234, -567, 3, -1, -1, 0, 100, 1844245, 1);

        foreach (vecs[k]) begin
            v = vecs[k];
            load(v);
            run_scan(v.th, vcyc, npulse, aerr, berr);
            check({v.name, "_valid_cycle"}, 64'(vcyc), 64'd260);
            check({v.name, "_valid_pulses"}, 64'(npulse), 64'd1);
            check({v.name, "_addr_seq_errs"}, 64'(aerr), 64'd0);
            check({v.name, "_busy_errs"}, 64'(berr), 64'd0);
            check({v.name, "_peak_bin"}, 64'(bus.peak_bin), 64'(v.exp_bin));
            check({v.name, "_peak_mag"}, 64'(bus.peak_mag), 64'(v.exp_mag));
            check({v.name, "_peak_found"}, 64'(bus.peak_found), 64'(v.exp_found));
        end

        // Reset mid-scan, then a clean scan must still give the right answer
        load(vecs[0]);
        @(negedge clk);
        bus.thresh   = '0;
        bus.fft_done = 1'b1;
        @(negedge clk);
        bus.fft_done = 1'b0;
        for (int c = 1; c < 100; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_add_rd", 64'(bus.add_rd), 64'd0);
        check("midrst_peak_bin", 64'(bus.peak_bin), 64'd0);
        check("midrst_peak_mag", 64'(bus.peak_mag), 64'd0);
        check("midrst_peak_found", 64'(bus.peak_found), 64'd0);
        check("midrst_peak_valid", 64'(bus.peak_valid), 64'd0);
        reset  = 1'b0;
        npulse = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.peak_valid === 1'b1) npulse++;
        end
        check("midrst_no_valid", 64'(npulse), 64'd0);
        run_scan(33'd0, vcyc, npulse, aerr, berr);
        check("after_rst_valid_cycle", 64'(vcyc), 64'd260);
        check("after_rst_peak_bin", 64'(bus.peak_bin), 64'd37);
        check("after_rst_peak_mag", 64'(bus.peak_mag), 64'd1000000);

        // fft_done held high with an extra edge during the scan
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        mem[77] = pack_iq(0, -700);
        @(negedge clk);
        bus.thresh   = '0;
        bus.fft_done = 1'b1;
        vcyc = -1; npulse = 0;
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk);
            if (bus.peak_valid === 1'b1) begin
                npulse++;
                if (vcyc < 0) vcyc = c;
            end
            if (c == 50)  bus.fft_done = 1'b0;
            if (c == 52)  bus.fft_done = 1'b1;
            if (c == 600) bus.fft_done = 1'b0;
        end
        check("retrig_pulses", 64'(npulse), 64'd1);
        check("retrig_valid_cycle", 64'(vcyc), 64'd260);
        check("retrig_peak_bin", 64'(bus.peak_bin), 64'd77);
        check("retrig_peak_mag", 64'(bus.peak_mag), 64'd490000);
        check("retrig_busy_idle", 64'(bus.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
